sys_fifo_burst: RTL and testbench
=================================

Name: sys_fifo_burst

Overview:
Parametrised single-clock system FIFO for the PV solver pipeline. Write and read bursts are started by one-cycle triggers. Each trigger opens an enable window of exactly BURST cycles. The block keeps its own occupancy-checked storage with sticky overflow, underflow and trigger-drop flags. It drives a registered data output that either holds the last popped word or tracks the storage output once armed, selected by parameter. It replaces fixed-width, fixed-N FIFO wrappers between solver stages.

Parameters:
DATA_W, 64, data word width
DEPTH, 16, storage depth in words; power of two, minimum 4
BURST, 8, enable-window length in cycles per trigger (default overridden with `N_PV at instantiation); 1..DEPTH
HOLD_MODE, 1, 1 = dout updates only on popped words; 0 = dout tracks the storage read register every cycle once armed

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rst_user  in  1  synchronous abort of an active write burst; storage contents kept
flush  in  1  synchronous clear of pointers and count; aborts both bursts
clr_err  in  1  synchronous clear of sticky flags
wr_trig  in  1  write-burst start pulse
rd_trig  in  1  read-burst start pulse
din  in  DATA_W  write data, sampled on cycles where wr_en=1
dout  out  DATA_W  registered output data
dout_valid  out  1  one-cycle strobe when dout loads a popped word
wr_busy  out  1  write window open
rd_busy  out  1  read window open
usedw  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  out  1  usedw==DEPTH
empty  out  1  usedw==0
ovf  out  1  sticky: write attempted while full
udf  out  1  sticky: read attempted while empty
trig_drop  out  1  sticky: trigger arrived while its window was open

Behaviour:
- Reset: all outputs 0; pointers, count, window counters and the arm flag cleared; empty=1.
- Window generator, identical for read and write:
  - States IDLE and ACTIVE.
  - Trigger in IDLE at cycle T: enable is high on T+1..T+BURST, then IDLE.
  - Trigger while ACTIVE, including the last active cycle: ignored, trig_drop set.
  - busy equals enable.
  - rst_user forces the write window to IDLE; wr_en is low from the next cycle.
  - flush forces both windows to IDLE.
  - Simultaneous trigger and abort: abort wins, trigger dropped, no flag.
- Write:
  - Cycle with wr_en and not full: din is stored, wptr++ modulo DEPTH.
  - wr_en and full: no write, ovf set.
  - Exception: full with an accepted read in the same cycle; the write is accepted and usedw is unchanged.
- Read:
  - Cycle with rd_en and not empty: rptr++ and the word is loaded into the read register one cycle later (T_pop+1).
  - rd_en and empty: nothing read, udf set.
  - An empty FIFO with a simultaneous write still underflows; no fall-through.
- usedw: +1 for a write only, -1 for a read only, unchanged for both or neither; always within 0..DEPTH.
- Output path:
  - The arm flag is set on the cycle after the first accepted read.
  - HOLD_MODE=1: dout loads the read register at T_pop+2, dout_valid=1 that cycle, otherwise dout holds.
  - HOLD_MODE=0: once armed, dout follows the read register every cycle; dout_valid is as in HOLD_MODE=1.
  - Total latency rd_trig(T) -> first dout_valid: T+3.
- flush:
  - Pointers, usedw and both windows clear next cycle.
  - Pops already in the read pipeline still complete.
  - Storage contents and dout are untouched; sticky flags keep their values.
  - flush has priority over same-cycle reads and writes, which are discarded without flagging.
- clr_err: clears all sticky flags. A same-cycle new error event wins (flag stays 1).
- Storage is an inferred RAM: synchronous write, registered read. No vendor IP.

Decomposition:
- Global parameter header: default BURST (`N_PV) and a clog2 macro/function shared with other FIFOs.
- One sub-module, burst_ena_gen: parameter BURST; ports clk, rst, trig, abort, en, drop. Instantiated twice, with the write instance's abort = rst_user|flush and the read instance's abort = flush.
- RAM, pointers, count, flags and output register stay in sys_fifo_burst.

Test Plan:
- Defaults DATA_W=64, DEPTH=16, BURST=4. wr_trig@T0 with din=1,2,3,4 on T1..T4, then rd_trig@T10 -> wr_en high T1..T4, usedw=4 at T5; rd_en high T11..T14; dout_valid T13..T16 with dout 1,2,3,4; usedw=0 at T15; HOLD_MODE=1 leaves dout=4 afterwards.
- Five write bursts (20 words) into DEPTH=16 -> full at word 16; ovf=1; usedw=16; read back of 16 words returns words 1..16.
- Read burst on empty FIFO -> no dout_valid, udf=1, usedw=0. Then clr_err -> udf=0 next cycle.
- wr_trig again two cycles into an active write window -> trig_drop=1, window still ends after 4 cycles. rst_user in the 2nd window cycle -> only 2 words written, usedw=2.
- FIFO at full=16 with simultaneous read and write windows -> usedw stays 16, no ovf, data order preserved.
- flush with usedw=7 -> usedw=0 and empty=1 next cycle, both busy=0, flags unchanged. HOLD_MODE=0 build: dout changes every cycle once armed.

Source files
------------

// File: rtl/sys_fifo_burst_pkg.sv
// Shared definitions for the burst FIFO family: the default burst length,
// the window-generator state encoding and a constant ceil-log2 helper.
`ifndef N_PV
`define N_PV 8
`endif

package sys_fifo_burst_pkg;

   localparam int N_PV = `N_PV;

   typedef enum logic {
      WIN_IDLE   = 1'b0,
      WIN_ACTIVE = 1'b1
   } win_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/sys_fifo_burst_ena_gen.sv
// Enable-window generator: a one-cycle trigger opens a window of exactly
// BURST cycles. Triggers landing inside an open window are reported on
// drop and otherwise ignored. An abort closes the window and swallows any
// same-cycle trigger without reporting it.
module burst_ena_gen
   import sys_fifo_burst_pkg::*;
#(
   parameter int BURST = N_PV
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   input  logic abort,
   output logic en,
   output logic drop
);

   localparam int CW = clog2(BURST + 1);
   localparam logic [CW-1:0] LAST = CW'(BURST - 1);

   win_state_t    state;
   win_state_t    state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // Window state and beat counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= WIN_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Open on trigger, close after the last beat or on abort
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      en        = 1'b0;
      drop      = 1'b0;
      case (state)
         WIN_IDLE: begin
            if (trig && !abort) begin
               state_nxt = WIN_ACTIVE;
               cnt_nxt   = '0;
            end
         end
         WIN_ACTIVE: begin
            en = 1'b1;
            if (abort) begin
               state_nxt = WIN_IDLE;
            end else begin
               drop = trig;
               if (cnt == LAST) begin
                  state_nxt = WIN_IDLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = WIN_IDLE;
      endcase
   end

endmodule

// File: rtl/sys_fifo_burst.sv
// Single-clock burst FIFO between PV solver stages. Trigger pulses open
// fixed-length write/read windows; storage is an inferred RAM with a
// registered read, followed by an output register that either holds the
// last popped word or tracks the read register once armed.
module sys_fifo_burst
   import sys_fifo_burst_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int DEPTH     = 16,
   parameter int BURST     = N_PV,
   parameter int HOLD_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rst_user,
   input  logic                     flush,
   input  logic                     clr_err,
   input  logic                     wr_trig,
   input  logic                     rd_trig,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     dout_valid,
   output logic                     wr_busy,
   output logic                     rd_busy,
   output logic [$clog2(DEPTH):0]   usedw,
   output logic                     full,
   output logic                     empty,
   output logic                     ovf,
   output logic                     udf,
   output logic                     trig_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

   logic              wr_en;
   logic              rd_en;
   logic              wr_drop;
   logic              rd_drop;
   logic              wr_ok;
   logic              rd_ok;
   logic              ovf_set;
   logic              udf_set;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_q;
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [AW:0]       count;
   logic              pop_d1;
   logic              armed;

   burst_ena_gen #(.BURST(BURST)) u_wr_win (
      .clk   (clk),
      .rst   (rst),
      .trig  (wr_trig),
      .abort (rst_user | flush),
      .en    (wr_en),
      .drop  (wr_drop)
   );

   burst_ena_gen #(.BURST(BURST)) u_rd_win (
      .clk   (clk),
      .rst   (rst),
      .trig  (rd_trig),
      .abort (flush),
      .en    (rd_en),
      .drop  (rd_drop)
   );

   // A full FIFO still accepts a write when a read frees a slot that same cycle;
   // an empty FIFO never forwards a same-cycle write to the read side.
   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign usedw   = count;
   assign wr_busy = wr_en;
   assign rd_busy = rd_en;
   assign rd_ok   = rd_en & ~flush & ~empty;
   assign wr_ok   = wr_en & ~flush & (~full | rd_ok);
   assign ovf_set = wr_en & ~flush & full & ~rd_ok;
   assign udf_set = rd_en & ~flush & empty;

   // Inferred RAM: synchronous write, free-running registered read at rptr
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wptr] <= din;
      end
      rd_q <= mem[rptr];
   end

   // Pointers and occupancy; flush discards any same-cycle access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_ok) begin
            rptr <= rptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output register: popped words land two cycles after the pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pop_d1     <= 1'b0;
         armed      <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         pop_d1     <= rd_ok;
         dout_valid <= pop_d1;
         if (rd_ok) begin
            armed <= 1'b1;
         end
         if (HOLD_MODE != 0) begin
            if (pop_d1) begin
               dout <= rd_q;
            end
         end else if (armed) begin
            dout <= rd_q;
         end
      end
   end

   // Sticky error flags; a new event beats a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf       <= 1'b0;
         udf       <= 1'b0;
         trig_drop <= 1'b0;
      end else begin
         ovf       <= ovf_set | (ovf & ~clr_err);
         udf       <= udf_set | (udf & ~clr_err);
         trig_drop <= wr_drop | rd_drop | (trig_drop & ~clr_err);
      end
   end

endmodule

// File: tb/tb_sys_fifo_burst.sv
// Directed bench for sys_fifo_burst (DEPTH=16, BURST=4). A HOLD_MODE=1
// instance is checked throughout; a HOLD_MODE=0 twin shares the stimulus
// and has its output path checked where it differs.
module tb_sys_fifo_burst;

   logic        clk;
   logic        rst;
   logic        rst_user;
   logic        flush;
   logic        clr_err;
   logic        wr_trig;
   logic        rd_trig;
   logic [63:0] din;

   logic [63:0] dout;
   logic        dout_valid;
   logic        wr_busy;
   logic        rd_busy;
   logic [4:0]  usedw;
   logic        full;
   logic        empty;
   logic        ovf;
   logic        udf;
   logic        trig_drop;

   logic [63:0] dout0;
   logic        dout_valid0;
   logic        wr_busy0;
   logic        rd_busy0;
   logic [4:0]  usedw0;
   logic        full0;
   logic        empty0;
   logic        ovf0;
   logic        udf0;
   logic        trig_drop0;

   int          tests_run;
   int          tests_failed;
   logic [63:0] got[$];

   sys_fifo_burst #(.DATA_W(64), .DEPTH(16), .BURST(4), .HOLD_MODE(1)) dut (
      .clk(clk), .rst(rst), .rst_user(rst_user), .flush(flush), .clr_err(clr_err),
      .wr_trig(wr_trig), .rd_trig(rd_trig), .din(din),
      .dout(dout), .dout_valid(dout_valid), .wr_busy(wr_busy), .rd_busy(rd_busy),
      .usedw(usedw), .full(full), .empty(empty), .ovf(ovf), .udf(udf),
      .trig_drop(trig_drop)
   );

   sys_fifo_burst #(.DATA_W(64), .DEPTH(16), .BURST(4), .HOLD_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .rst_user(rst_user), .flush(flush), .clr_err(clr_err),
      .wr_trig(wr_trig), .rd_trig(rd_trig), .din(din),
      .dout(dout0), .dout_valid(dout_valid0), .wr_busy(wr_busy0), .rd_busy(rd_busy0),
      .usedw(usedw0), .full(full0), .empty(empty0), .ovf(ovf0), .udf(udf0),
      .trig_drop(trig_drop0)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_burst(input logic [63:0] first);
      wr_trig = 1'b1;
      step();
      wr_trig = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din = first + 64'(i);
         step();
      end
      din = '0;
   endtask

   task automatic read_collect(input int nbursts);
      got.delete();
      for (int b = 0; b < nbursts; b++) begin
         rd_trig = 1'b1;
         for (int c = 0; c < 6; c++) begin
            step();
            rd_trig = 1'b0;
            if (dout_valid === 1'b1) got.push_back(dout);
         end
      end
      for (int c = 0; c < 4; c++) begin
         step();
         if (dout_valid === 1'b1) got.push_back(dout);
      end
   endtask

   task automatic test_reset();
      tests_run++; if (usedw !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_usedw: got %0d want 0", usedw); end
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
      tests_run++; if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full: got %b want 0", full); end
      tests_run++; if (dout !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset_dout: got %0h want 0", dout); end
      tests_run++; if (dout0 !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset_dout0: got %0h want 0", dout0); end
      tests_run++; if ({dout_valid, wr_busy, rd_busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_strobes: got %b want 000", {dout_valid, wr_busy, rd_busy}); end
      tests_run++; if ({ovf, udf, trig_drop} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b want 000", {ovf, udf, trig_drop}); end
   endtask

   task automatic test_basic_burst();
      logic exp_busy;
      logic exp_v;
      wr_trig = 1'b1;
      step();
      wr_trig = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tests_run++; if (wr_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_wr_busy_T%0d: got %b want 1", i, wr_busy); end
         din = 64'(i);
         step();
      end
      din = '0;
      tests_run++; if (wr_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_wr_busy_T5: got %b want 0", wr_busy); end
      tests_run++; if (usedw !== 5'd4) begin tests_failed++; $display("[TB] FAIL basic_usedw_T5: got %0d want 4", usedw); end
      repeat (5) step();
      rd_trig = 1'b1;
      step();
      rd_trig = 1'b0;
      for (int t = 11; t <= 17; t++) begin
         exp_busy = (t <= 14);
         exp_v    = (t >= 13 && t <= 16);
         tests_run++; if (rd_busy !== exp_busy) begin tests_failed++; $display("[TB] FAIL basic_rd_busy_T%0d: got %b want %b", t, rd_busy, exp_busy); end
         tests_run++; if (dout_valid !== exp_v) begin tests_failed++; $display("[TB] FAIL basic_valid_T%0d: got %b want %b", t, dout_valid, exp_v); end
         if (exp_v) begin
            tests_run++; if (dout !== 64'(t - 12)) begin tests_failed++; $display("[TB] FAIL basic_dout_T%0d: got %0h want %0h", t, dout, t - 12); end
            tests_run++; if (dout0 !== 64'(t - 12)) begin tests_failed++; $display("[TB] FAIL basic_dout0_T%0d: got %0h want %0h", t, dout0, t - 12); end
         end
         if (t == 15) begin
            tests_run++; if (usedw !== 5'd0) begin tests_failed++; $display("[TB] FAIL basic_usedw_T15: got %0d want 0", usedw); end
         end
         if (t == 17) begin
            tests_run++; if (dout !== 64'd4) begin tests_failed++; $display("[TB] FAIL basic_hold_T17: got %0h want 4", dout); end
         end
         step();
      end
   endtask

   task automatic test_hold_mode();
      write_burst(64'hA0);
      step();
      step();
      tests_run++; if (dout !== 64'd4) begin tests_failed++; $display("[TB] FAIL hold_dout: got %0h want 4", dout); end
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_valid: got %b want 0", dout_valid); end
      tests_run++; if (dout0 !== 64'hA0) begin tests_failed++; $display("[TB] FAIL hold_track_dout0: got %0h want a0", dout0); end
      tests_run++; if (usedw !== 5'd4) begin tests_failed++; $display("[TB] FAIL hold_usedw: got %0d want 4", usedw); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      tests_run++; if (usedw !== 5'd0) begin tests_failed++; $display("[TB] FAIL hold_flush_usedw: got %0d want 0", usedw); end
   endtask

   task automatic test_underflow();
      rd_trig = 1'b1;
      step();
      rd_trig = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL udf_valid_R%0d: got %b want 0", c, dout_valid); end
         step();
      end
      tests_run++; if (udf !== 1'b1) begin tests_failed++; $display("[TB] FAIL udf_flag: got %b want 1", udf); end
      tests_run++; if (usedw !== 5'd0) begin tests_failed++; $display("[TB] FAIL udf_usedw: got %0d want 0", usedw); end
      tests_run++; if (dout !== 64'd4) begin tests_failed++; $display("[TB] FAIL udf_dout: got %0h want 4", dout); end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      tests_run++; if (udf !== 1'b0) begin tests_failed++; $display("[TB] FAIL udf_clear: got %b want 0", udf); end
   endtask

   task automatic test_overflow();
      for (int b = 0; b < 4; b++) write_burst(64'(1 + 4 * b));
      tests_run++; if (full !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_full16: got %b want 1", full); end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_early: got %b want 0", ovf); end
      write_burst(64'd17);
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_flag: got %b want 1", ovf); end
      tests_run++; if (usedw !== 5'd16) begin tests_failed++; $display("[TB] FAIL ovf_usedw: got %0d want 16", usedw); end
      read_collect(4);
      tests_run++; if (got.size() !== 16) begin tests_failed++; $display("[TB] FAIL ovf_count: got %0d want 16", got.size()); end
      for (int i = 0; i < got.size() && i < 16; i++) begin
         tests_run++; if (got[i] !== 64'(i + 1)) begin tests_failed++; $display("[TB] FAIL ovf_word%0d: got %0h want %0h", i, got[i], i + 1); end
      end
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_drained: got %b want 1", empty); end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_clear: got %b want 0", ovf); end
   endtask

   task automatic test_drop_abort();
      wr_trig = 1'b1;
      step();
      wr_trig = 1'b0;
      din = 64'h31;
      step();
      wr_trig = 1'b1;
      din = 64'h32;
      step();
      wr_trig = 1'b0;
      tests_run++; if (trig_drop !== 1'b1) begin tests_failed++; $display("[TB] FAIL drop_flag: got %b want 1", trig_drop); end
      tests_run++; if (wr_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL drop_busy_W3: got %b want 1", wr_busy); end
      din = 64'h33;
      step();
      tests_run++; if (wr_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL drop_busy_W4: got %b want 1", wr_busy); end
      din = 64'h34;
      step();
      din = '0;
      tests_run++; if (wr_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_busy_W5: got %b want 0", wr_busy); end
      tests_run++; if (usedw !== 5'd4) begin tests_failed++; $display("[TB] FAIL drop_usedw: got %0d want 4", usedw); end
      clr_err = 1'b1;
      flush = 1'b1;
      step();
      clr_err = 1'b0;
      flush = 1'b0;
      tests_run++; if (trig_drop !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_clear: got %b want 0", trig_drop); end
      wr_trig = 1'b1;
      rst_user = 1'b1;
      step();
      wr_trig = 1'b0;
      rst_user = 1'b0;
      tests_run++; if (wr_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_wins_busy: got %b want 0", wr_busy); end
      tests_run++; if (trig_drop !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_wins_flag: got %b want 0", trig_drop); end
      wr_trig = 1'b1;
      step();
      wr_trig = 1'b0;
      din = 64'h41;
      step();
      din = 64'h42;
      rst_user = 1'b1;
      step();
      rst_user = 1'b0;
      din = '0;
      tests_run++; if (wr_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b want 0", wr_busy); end
      step();
      tests_run++; if (usedw !== 5'd2) begin tests_failed++; $display("[TB] FAIL abort_usedw: got %0d want 2", usedw); end
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic test_full_concurrent();
      logic [63:0] exp;
      for (int b = 0; b < 4; b++) write_burst(64'(101 + 4 * b));
      tests_run++; if (usedw !== 5'd16) begin tests_failed++; $display("[TB] FAIL conc_fill: got %0d want 16", usedw); end
      got.delete();
      wr_trig = 1'b1;
      rd_trig = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         wr_trig = 1'b0;
         rd_trig = 1'b0;
         din = (c <= 4) ? 64'(200 + c) : 64'd0;
         tests_run++; if (usedw !== 5'd16) begin tests_failed++; $display("[TB] FAIL conc_usedw_C%0d: got %0d want 16", c, usedw); end
         if (dout_valid === 1'b1) got.push_back(dout);
      end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL conc_ovf: got %b want 0", ovf); end
      tests_run++; if (got.size() !== 4) begin tests_failed++; $display("[TB] FAIL conc_pop_count: got %0d want 4", got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         tests_run++; if (got[i] !== 64'(101 + i)) begin tests_failed++; $display("[TB] FAIL conc_pop%0d: got %0d want %0d", i, got[i], 101 + i); end
      end
      read_collect(4);
      tests_run++; if (got.size() !== 16) begin tests_failed++; $display("[TB] FAIL conc_drain_count: got %0d want 16", got.size()); end
      for (int i = 0; i < got.size() && i < 16; i++) begin
         exp = (i < 12) ? 64'(105 + i) : 64'(201 + i - 12);
         tests_run++; if (got[i] !== exp) begin tests_failed++; $display("[TB] FAIL conc_word%0d: got %0d want %0d", i, got[i], exp); end
      end
      tests_run++; if (usedw !== 5'd0) begin tests_failed++; $display("[TB] FAIL conc_usedw_end: got %0d want 0", usedw); end
   endtask

   task automatic test_flush();
      wr_trig = 1'b1;
      step();
      wr_trig = 1'b0;
      din = 64'd51;
      step();
      wr_trig = 1'b1;
      din = 64'd52;
      step();
      wr_trig = 1'b0;
      din = 64'd53;
      step();
      din = 64'd54;
      step();
      wr_trig = 1'b1;
      step();
      wr_trig = 1'b0;
      din = 64'd55;
      step();
      din = 64'd56;
      step();
      din = 64'd57;
      rst_user = 1'b1;
      step();
      rst_user = 1'b0;
      din = '0;
      tests_run++; if (usedw !== 5'd7) begin tests_failed++; $display("[TB] FAIL flush_pre_usedw: got %0d want 7", usedw); end
      wr_trig = 1'b1;
      rd_trig = 1'b1;
      step();
      wr_trig = 1'b0;
      rd_trig = 1'b0;
      tests_run++; if ({wr_busy, rd_busy} !== 2'b11) begin tests_failed++; $display("[TB] FAIL flush_pre_busy: got %b want 11", {wr_busy, rd_busy}); end
      flush = 1'b1;
      din = 64'd99;
      step();
      flush = 1'b0;
      din = '0;
      tests_run++; if (usedw !== 5'd0) begin tests_failed++; $display("[TB] FAIL flush_usedw: got %0d want 0", usedw); end
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_empty: got %b want 1", empty); end
      tests_run++; if ({wr_busy, rd_busy} !== 2'b00) begin tests_failed++; $display("[TB] FAIL flush_busy: got %b want 00", {wr_busy, rd_busy}); end
      tests_run++; if ({ovf, udf, trig_drop} !== 3'b001) begin tests_failed++; $display("[TB] FAIL flush_flags: got %b want 001", {ovf, udf, trig_drop}); end
      tests_run++; if (dout !== 64'd204) begin tests_failed++; $display("[TB] FAIL flush_dout: got %0d want 204", dout); end
      step();
      tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_valid_F3: got %b want 0", dout_valid); end
      step();
      tests_run++; if (dout !== 64'd204) begin tests_failed++; $display("[TB] FAIL flush_dout_F4: got %0d want 204", dout); end
      tests_run++; if (usedw !== 5'd0) begin tests_failed++; $display("[TB] FAIL flush_usedw_F4: got %0d want 0", usedw); end
   endtask

   // Reset, then run each scenario in order and report
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst      = 1'b1;
      rst_user = 1'b0;
      flush    = 1'b0;
      clr_err  = 1'b0;
      wr_trig  = 1'b0;
      rd_trig  = 1'b0;
      din      = '0;
      repeat (3) step();
      rst = 1'b0;
      test_reset();
      step();
      test_basic_burst();
      test_hold_mode();
      test_underflow();
      test_overflow();
      test_drop_abort();
      test_full_concurrent();
      test_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
